// File: rtl/jtkunio_pcm_pkg.sv
// jtkunio_pcm_pkg: shared types and constants for the PCM ROM fetcher
package jtkunio_pcm_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic LOW_FIRST    = 1'b0;
  localparam logic FETCH_DEMAND = 1'b0;
  localparam logic FETCH_PREF   = 1'b1;
endpackage

// File: rtl/jtkunio_pcm_buf.sv
// jtkunio_pcm_buf: 2-entry word buffer with tag compare, lru and registered byte output
module jtkunio_pcm_buf
  import jtkunio_pcm_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic [AW-2:0] ptag,
  input  logic          wr,
  input  logic [AW-2:0] wtag,
  input  logic [15:0]   wdata,
  output logic          hit,
  output logic          phit,
  output logic          ok,
  output logic [7:0]    dout
);
  logic [1:0]    valid;
  logic [AW-2:0] tag [2];
  logic [15:0]   data [2];
  logic          lru;
  logic [1:0]    match;
  logic [15:0]   word;
  assign match = {valid[1] && tag[1] == addr[AW-1:1], valid[0] && tag[0] == addr[AW-1:1]};
  assign hit   = |match;
  assign phit  = (valid[0] && tag[0] == ptag) || (valid[1] && tag[1] == ptag);
  assign word  = match[1] ? data[1] : data[0];
  // a fill always claims the lru entry and overrides any hit-driven lru update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 2'b00;
      lru   <= 1'b0;
      ok    <= 1'b0;
      dout  <= 8'h00;
    end else begin
      ok <= cs && hit;
      if (cs && hit) dout <= addr[0] == LOW_FIRST ? word[7:0] : word[15:8];
      if (wr) begin
        valid[lru] <= 1'b1;
        tag[lru]   <= wtag;
        data[lru]  <= wdata;
        lru        <= ~lru;
      end else if (cs && hit) lru <= ~match[1];
    end
  end
endmodule

// File: rtl/jtkunio_pcm_fetch.sv
// jtkunio_pcm_fetch: PCM ROM byte responder fetching 16-bit words from SDRAM with one-word prefetch
module jtkunio_pcm_fetch
  import jtkunio_pcm_pkg::*;
#(
  parameter int AW       = 17,
  parameter bit PREFETCH = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic [7:0]    dout,
  output logic          ok,
  output logic [AW-2:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dok,
  input  logic [15:0]   sdram_data
);
  state_t        st, st_nx;
  logic          req_nx, kind, kind_nx, pend, pend_nx, fill, hit, phit;
  logic [AW-2:0] addr_nx, pend_addr, pend_addr_nx;
  jtkunio_pcm_buf #(.AW(AW)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (cs),
    .addr  (addr),
    .ptag  (pend_addr),
    .wr    (fill),
    .wtag  (sdram_addr),
    .wdata (sdram_data),
    .hit   (hit),
    .phit  (phit),
    .ok    (ok),
    .dout  (dout)
  );
  // a pending word already in the buffer is simply dropped instead of refetched
  always_comb begin
    st_nx        = st;
    req_nx       = sdram_req;
    addr_nx      = sdram_addr;
    kind_nx      = kind;
    pend_nx      = pend;
    pend_addr_nx = pend_addr;
    fill         = 1'b0;
    case (st)
      IDLE: begin
        if (cs && !hit) begin
          addr_nx = addr[AW-1:1];
          kind_nx = FETCH_DEMAND;
          pend_nx = 1'b0;
          req_nx  = 1'b1;
          st_nx   = REQ;
        end else if (pend) begin
          pend_nx = 1'b0;
          if (!phit) begin
            addr_nx = pend_addr;
            kind_nx = FETCH_PREF;
            req_nx  = 1'b1;
            st_nx   = REQ;
          end
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_nx = 1'b0;
          fill   = sdram_dok;
          st_nx  = sdram_dok ? IDLE : WAIT;
        end
      end
      WAIT: begin
        fill  = sdram_dok;
        st_nx = sdram_dok ? IDLE : WAIT;
      end
      default: st_nx = IDLE;
    endcase
    if (fill && kind == FETCH_DEMAND && PREFETCH) begin
      pend_nx      = 1'b1;
      pend_addr_nx = sdram_addr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      kind       <= FETCH_DEMAND;
      pend       <= 1'b0;
      pend_addr  <= '0;
    end else begin
      st         <= st_nx;
      sdram_req  <= req_nx;
      sdram_addr <= addr_nx;
      kind       <= kind_nx;
      pend       <= pend_nx;
      pend_addr  <= pend_addr_nx;
    end
  end
endmodule

// File: tb/tb_jtkunio_pcm_fetch.sv
// tb_jtkunio_pcm_fetch: randomized bench with a transaction-level buffer model and SDRAM responder
module tb_jtkunio_pcm_fetch;
  logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b0;
  logic [16:0] addr = '0;
  logic [7:0]  dout;
  logic        ok, sdram_req;
  logic [15:0] sdram_addr;
  logic        sdram_ack = 1'b0, sdram_dok = 1'b0;
  logic [15:0] sdram_data = '0;

  jtkunio_pcm_fetch dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .dout(dout), .ok(ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_dok(sdram_dok), .sdram_data(sdram_data)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  // model: buffer contents as tags only, data comes from the rom function
  bit [1:0]    m_v;
  logic [15:0] m_tag [2];
  bit          m_lru, m_ok, m_pend, m_dem;
  logic [7:0]  m_dout;
  int          m_busy;
  logic [15:0] m_saddr, m_paddr;
  // responder
  bit          r_busy;
  int          r_cnt, r_ack, r_dok, ack_fix = -1, dok_fix = -1, req_seen = 0;
  logic [15:0] r_addr, last_req;
  int          fetch_cnt [int];

  function automatic logic [15:0] rom(input logic [15:0] w);
    return w == 16'h0008 ? 16'hA55A : w * 16'h9E37 + 16'h1234;
  endfunction

  function automatic logic [7:0] byte_of(input logic [16:0] a);
    logic [15:0] w;
    w = rom(a[16:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic bit buffered(input logic [15:0] w);
    return (m_v[0] && m_tag[0] == w) || (m_v[1] && m_tag[1] == w);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    else passed++;
  endtask

  task automatic model_step();
    int hi, ob;
    bit fill;
    logic [15:0] w;
    if (!rst_n) begin
      m_v = 2'b00; m_lru = 0; m_ok = 0; m_dout = 8'h00; m_busy = 0;
      m_pend = 0; m_dem = 0; m_saddr = '0; m_paddr = '0;
      return;
    end
    w  = addr[16:1];
    hi = (m_v[0] && m_tag[0] == w) ? 0 : (m_v[1] && m_tag[1] == w) ? 1 : -1;
    ob = m_busy;
    fill = (ob == 1 && sdram_ack && sdram_dok) || (ob == 2 && sdram_dok);
    m_ok = cs && hi >= 0;
    if (m_ok) m_dout = byte_of(addr);
    if (fill) begin
      m_v[m_lru] = 1'b1;
      m_tag[m_lru] = m_saddr;
      m_lru = !m_lru;
      if (m_dem) begin
        m_pend = 1;
        m_paddr = m_saddr + 16'd1;
      end
    end else if (m_ok) m_lru = (hi == 0);
    if (ob == 1 && sdram_ack) m_busy = sdram_dok ? 0 : 2;
    else if (ob == 2 && sdram_dok) m_busy = 0;
    if (ob == 0) begin
      if (cs && hi < 0) begin
        m_saddr = w; m_dem = 1; m_pend = 0; m_busy = 1;
      end else if (m_pend) begin
        m_pend = 0;
        if (!buffered(m_paddr)) begin
          m_saddr = m_paddr; m_dem = 0; m_busy = 1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("ok", ok, m_ok);
    chk("dout", dout, m_dout);
    chk("req", sdram_req, m_busy == 1);
    chk("sdram_addr", sdram_addr, m_saddr);
  endtask

  task automatic respond();
    if (r_busy) begin
      r_cnt++;
      if (r_cnt > r_dok) r_busy = 0;
    end
    if (r_busy && r_cnt > r_ack) chk("req_overlap", sdram_req, 0);
    if (!r_busy && sdram_req) begin
      r_busy = 1; r_cnt = 0;
      r_ack = ack_fix >= 0 ? ack_fix : int'($urandom_range(0, 4));
      r_dok = dok_fix >= 0 ? dok_fix : r_ack + int'($urandom_range(0, 4));
      r_addr = sdram_addr; last_req = sdram_addr;
      req_seen++;
      fetch_cnt[int'(sdram_addr)]++;
    end
    sdram_ack  = r_busy && r_cnt == r_ack;
    sdram_dok  = r_busy && r_cnt == r_dok;
    sdram_data = sdram_dok ? rom(r_addr) : 16'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    respond();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_ok(input string n, input int bound);
    tick();
    for (int i = 0; i < bound && !ok; i++) tick();
    chk({n, "_ok_timeout"}, ok, 1);
  endtask

  task automatic wait_req(input string n, input int target, input int bound);
    for (int i = 0; i < bound && req_seen < target; i++) tick();
    chk({n, "_req_timeout"}, req_seen >= target, 1);
  endtask

  initial begin
    int s0;
    // reset with cs held high
    cs = 1; addr = 17'h00010; ack_fix = 3; dok_fix = 6;
    run(3);
    chk("rst_req", sdram_req, 0);
    chk("rst_ok", ok, 0);
    chk("rst_dout", dout, 8'h00);
    // cold miss then prefetch of the next word
    rst_n = 1;
    s0 = req_seen;
    for (int i = 0; i < 2 && !sdram_req; i++) tick();
    chk("cold_req", sdram_req, 1);
    chk("cold_addr", sdram_addr, 16'h0008);
    wait_ok("cold", 20);
    chk("cold_dout", dout, 8'h5A);
    wait_req("pref", s0 + 2, 10);
    chk("pref_addr", last_req, 16'h0009);
    addr = 17'h00011;
    s0 = req_seen;
    tick();
    chk("hi_ok", ok, 1);
    chk("hi_dout", dout, 8'hA5);
    run(10);
    chk("hi_no_req", req_seen, s0);
    // streaming one byte every 8 cycles
    ack_fix = 2; dok_fix = 4;
    fetch_cnt.delete();
    for (int a = 17'h20; a <= 17'h3F; a++) begin
      addr = 17'(a);
      run(8);
      chk("stream_ok", ok, 1);
    end
    for (int w = 16'h10; w <= 16'h1F; w++)
      chk("stream_once", fetch_cnt.exists(w) ? fetch_cnt[w] : 0, 1);
    chk("stream_words", fetch_cnt.num(), 16);
    // word address wrap
    ack_fix = -1; dok_fix = -1;
    addr = 17'h1FFFE;
    s0 = req_seen;
    wait_ok("wrap", 40);
    chk("wrap_dout", dout, byte_of(17'h1FFFE));
    wait_req("wrap_pref", s0 + 2, 40);
    chk("wrap_pref_addr", last_req, 16'h0000);
    run(12);
    addr = 17'h1FFFF;
    tick();
    chk("wrap_hi_ok", ok, 1);
    chk("wrap_hi_dout", dout, byte_of(17'h1FFFF));
    addr = 17'h00000;
    s0 = req_seen;
    tick();
    chk("wrap0_ok", ok, 1);
    chk("wrap0_dout", dout, byte_of(17'h00000));
    chk("wrap0_no_req", req_seen, s0);
    // miss arriving while a prefetch waits for data
    ack_fix = 1; dok_fix = 8;
    addr = 17'h00100;
    s0 = req_seen;
    wait_ok("jmp_first", 30);
    for (int i = 0; i < 30 && !(req_seen == s0 + 2 && r_busy && r_cnt > r_ack); i++) tick();
    chk("jmp_pref_wait", req_seen == s0 + 2 && r_busy && r_cnt > r_ack, 1);
    chk("jmp_pref_addr", last_req, 16'h0081);
    addr = 17'h04000;
    wait_req("jmp_dem", s0 + 3, 30);
    chk("jmp_dem_addr", last_req, 16'h2000);
    wait_ok("jmp", 30);
    chk("jmp_dout", dout, byte_of(17'h04000));
    run(20);
    // ack and dok in the same cycle
    ack_fix = 3; dok_fix = 3;
    addr = 17'h00200;
    wait_ok("ackdok", 20);
    chk("ackdok_dout", dout, byte_of(17'h00200));
    run(12);
    // reset while waiting for data, dok arrives afterwards
    ack_fix = 1; dok_fix = 6;
    addr = 17'h00300;
    s0 = req_seen;
    for (int i = 0; i < 20 && !(req_seen > s0 && r_busy && r_cnt > r_ack); i++) tick();
    chk("mid_wait", req_seen > s0 && r_busy, 1);
    rst_n = 0; cs = 0;
    tick();
    rst_n = 1;
    run(8);
    chk("mid_ok", ok, 0);
    chk("mid_req", sdram_req, 0);
    cs = 1;
    tick();
    chk("mid_miss_ok", ok, 0);
    chk("mid_miss_req", sdram_req, 1);
    run(20);
    // random traffic
    ack_fix = -1; dok_fix = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) cs = ~cs;
      case ($urandom_range(0, 19))
        0: addr = 17'h00500 + 17'($urandom_range(0, 31));
        1: addr = 17'h1FFF0 + 17'($urandom_range(0, 15));
        2, 3, 4, 5, 6: addr = addr + 17'd1;
        default: ;
      endcase
      if (!r_busy && $urandom_range(0, 299) == 0) begin
        rst_n = 0;
        run(2);
        rst_n = 1;
      end
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
